// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between a producer and the UART transmit serializer.
interface uart_tx_serializer_if;
  logic [7:0] tx_dat;
  logic       tx_vld;
  logic       tx_rdy;

  modport master (output tx_dat, output tx_vld, input tx_rdy);
  modport slave  (input tx_dat, input tx_vld, output tx_rdy);
endinterface

// File: rtl/uart_tx_serializer.sv
// 16550-style UART transmitter: one-entry holding register feeding a frame shifter
// clocked by 16x baud ticks; start, 5-8 data bits, optional parity, 1/1.5/2 stop bits.
module uart_tx_serializer (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_baudout_clk,
  uart_tx_serializer_if.slave         s_tx,
  input  logic [1:0]                  i_wls,
  input  logic                        i_stb,
  input  logic                        i_pen,
  input  logic                        i_eps,
  input  logic                        i_sp,
  input  logic                        i_bc,
  output logic                        o_txd,
  output logic                        o_tx_empty
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t     r_state;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_idx;
  logic       r_baud_q;
  logic [7:0] r_thr;
  logic       r_thr_full;
  logic [7:0] r_sh;
  logic [1:0] r_wls;
  logic       r_stb;
  logic       r_pen;
  logic       r_par;
  logic       r_txd;
  logic       r_tx_empty;

  logic       w_tick;
  logic       w_bit_end;
  logic       w_stop_last;
  logic       w_load;
  logic       w_accept;
  logic       w_last_data;
  logic       w_par;
  logic [7:0] w_mask;
  logic [7:0] w_thr_m;

  assign w_tick    = i_baudout_clk & ~r_baud_q;
  assign w_bit_end = w_tick & (r_tick_cnt == 4'd15);

  // Second stop bit of a 5-bit word is cut to half length (1.5 stop bits).
  assign w_stop_last = (r_state == S_STOP) & w_tick &
                       (r_stb ? (r_bit_idx[0] & (r_tick_cnt == ((r_wls == 2'd0) ? 4'd7 : 4'd15)))
                              : (r_tick_cnt == 4'd15));

  assign w_load      = r_thr_full & ((r_state == S_IDLE) | w_stop_last);
  assign w_accept    = s_tx.tx_vld & ~r_thr_full;
  assign w_last_data = (r_bit_idx == ({1'b0, r_wls} + 3'd4));

  // Unused upper bits are zeroed so a full-byte XOR gives the parity of sent bits.
  assign w_mask  = ~(8'hE0 << i_wls);
  assign w_thr_m = r_thr & w_mask;
  assign w_par   = i_sp ? ~i_eps : (i_eps ? ^w_thr_m : ~^w_thr_m);

  assign s_tx.tx_rdy = ~r_thr_full;
  assign o_txd       = r_txd & ~i_bc;
  assign o_tx_empty  = r_tx_empty;

  always_ff @(posedge i_clk) begin
    r_baud_q <= i_baudout_clk;
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_thr      <= 8'd0;
      r_thr_full <= 1'b0;
      r_sh       <= 8'd0;
      r_wls      <= 2'd0;
      r_stb      <= 1'b0;
      r_pen      <= 1'b0;
      r_par      <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_empty <= 1'b1;
    end else begin
      r_tx_empty <= (r_state == S_IDLE) & ~r_thr_full;

      if (w_accept) begin
        r_thr      <= s_tx.tx_dat;
        r_thr_full <= 1'b1;
      end else if (w_load) begin
        r_thr_full <= 1'b0;
      end

      if (w_load) begin
        r_sh       <= w_thr_m;
        r_wls      <= i_wls;
        r_stb      <= i_stb;
        r_pen      <= i_pen;
        r_par      <= w_par;
        r_state    <= S_START;
        r_tick_cnt <= 4'd0;
        r_bit_idx  <= 3'd0;
        r_txd      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_tick_cnt <= 4'd0;
            r_txd      <= 1'b1;
          end
          S_START: begin
            if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
            if (w_bit_end) begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
              r_txd     <= r_sh[0];
            end
          end
          S_DATA: begin
            if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
            if (w_bit_end) begin
              if (!w_last_data) begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_txd     <= r_sh[r_bit_idx + 3'd1];
              end else if (r_pen) begin
                r_state <= S_PARITY;
                r_txd   <= r_par;
              end else begin
                r_state   <= S_STOP;
                r_bit_idx <= 3'd0;
                r_txd     <= 1'b1;
              end
            end
          end
          S_PARITY: begin
            if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;
            if (w_bit_end) begin
              r_state   <= S_STOP;
              r_bit_idx <= 3'd0;
              r_txd     <= 1'b1;
            end
          end
          S_STOP: begin
            if (w_tick) begin
              if (w_stop_last) begin
                r_state    <= S_IDLE;
                r_tick_cnt <= 4'd0;
                r_txd      <= 1'b1;
              end else if (r_tick_cnt == 4'd15) begin
                r_tick_cnt <= 4'd0;
                r_bit_idx  <= 3'd1;
              end else begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
